// File: rtl/main_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the shared main-memory slave port.
// Round-robin grant with cycle lock, plus a watchdog that errors a master the slave never answers.
module main_mem_arbiter #(
  parameter int unsigned WB_DWIDTH = 32,
  parameter int unsigned WB_SWIDTH = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,

  input  logic [31:0]          i_m0_adr,
  input  logic [WB_SWIDTH-1:0] i_m0_sel,
  input  logic                 i_m0_we,
  input  logic [WB_DWIDTH-1:0] i_m0_dat,
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  output logic [WB_DWIDTH-1:0] o_m0_dat,
  output logic                 o_m0_ack,
  output logic                 o_m0_err,

  input  logic [31:0]          i_m1_adr,
  input  logic [WB_SWIDTH-1:0] i_m1_sel,
  input  logic                 i_m1_we,
  input  logic [WB_DWIDTH-1:0] i_m1_dat,
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  output logic [WB_DWIDTH-1:0] o_m1_dat,
  output logic                 o_m1_ack,
  output logic                 o_m1_err,

  output logic [31:0]          o_s_adr,
  output logic [WB_SWIDTH-1:0] o_s_sel,
  output logic                 o_s_we,
  output logic [WB_DWIDTH-1:0] o_s_dat,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  input  logic [WB_DWIDTH-1:0] i_s_dat,
  input  logic                 i_s_ack,
  input  logic                 i_s_err,

  output logic [1:0]           o_grant
);

  localparam logic [7:0] WdLimit = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1,
    StDrain
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;  // 1: m1 was granted last, so m0 wins a tie
  logic [7:0] wd_q, wd_d;

  logic gnt0, gnt1;
  logic req0, req1;
  logic own_cyc, drain_cyc;
  logic stall, wd_fire;

  assign gnt0 = (state_q == StGnt0);
  assign gnt1 = (state_q == StGnt1);
  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;

  assign own_cyc   = gnt1 ? i_m1_cyc : i_m0_cyc;
  assign drain_cyc = last_q ? i_m1_cyc : i_m0_cyc;

  // Slave strobe is only nonzero while granted, so a fire always belongs to the owner.
  assign stall   = o_s_stb & ~i_s_ack & ~i_s_err;
  assign wd_fire = stall & (wd_q == WdLimit);

  assign o_grant = {gnt1, gnt0};

  always_comb begin
    o_s_adr = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    o_s_dat = '0;
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    case (state_q)
      StGnt0: begin
        o_s_adr = i_m0_adr;
        o_s_sel = i_m0_sel;
        o_s_we  = i_m0_we;
        o_s_dat = i_m0_dat;
        o_s_cyc = i_m0_cyc;
        o_s_stb = i_m0_cyc & i_m0_stb;
      end
      StGnt1: begin
        o_s_adr = i_m1_adr;
        o_s_sel = i_m1_sel;
        o_s_we  = i_m1_we;
        o_s_dat = i_m1_dat;
        o_s_cyc = i_m1_cyc;
        o_s_stb = i_m1_cyc & i_m1_stb;
      end
      default: ;
    endcase
  end

  // A master that has dropped cyc has abandoned the access; late responses are discarded.
  assign o_m0_ack = gnt0 & i_m0_cyc & i_s_ack & ~i_s_err & ~i_rst;
  assign o_m0_err = gnt0 & i_m0_cyc & (i_s_err | wd_fire) & ~i_rst;
  assign o_m0_dat = gnt0 ? i_s_dat : '0;

  assign o_m1_ack = gnt1 & i_m1_cyc & i_s_ack & ~i_s_err & ~i_rst;
  assign o_m1_err = gnt1 & i_m1_cyc & (i_s_err | wd_fire) & ~i_rst;
  assign o_m1_dat = gnt1 ? i_s_dat : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_q ? StGnt0 : StGnt1;
        end else if (req0) begin
          state_d = StGnt0;
        end else if (req1) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (!own_cyc) begin
          state_d = StIdle;
          last_d  = gnt1;
        end else if (wd_fire) begin
          // Pointer records the stuck master so DRAIN knows whose cyc to wait on.
          state_d = StDrain;
          last_d  = gnt1;
        end else if (stall) begin
          wd_d = wd_q + 8'd1;
        end
      end
      StDrain: begin
        if (!drain_cyc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a rule-level model of ownership, pointer and watchdog.
module tb_main_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [31:0] o_m0_dat, o_m1_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0] o_s_adr, o_s_dat;
  logic [3:0]  o_s_sel;
  logic        o_s_we, o_s_cyc, o_s_stb;
  logic [31:0] s_dat;
  logic        s_ack, s_err;
  logic [1:0]  o_grant;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  main_mem_arbiter #(
    .WB_DWIDTH(32),
    .WB_SWIDTH(4),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_m0_adr(m0_adr), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_dat(m0_dat),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(m1_adr), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_dat(m1_dat),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr (o_s_adr), .o_s_sel(o_s_sel), .o_s_we(o_s_we), .o_s_dat(o_s_dat),
    .o_s_cyc (o_s_cyc), .o_s_stb(o_s_stb),
    .i_s_dat (s_dat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant (o_grant)
  );

  // Memory stub: writes ack with the strobe, reads ack two cycles after the strobe appears.
  logic        mute, force_ack, force_err;
  logic [1:0]  rd_wait;
  logic [31:0] mem [16];

  always_comb begin
    s_ack = force_ack | (~mute & o_s_stb & (o_s_we | (rd_wait == 2'd2)));
    s_err = force_err;
    s_dat = mem[o_s_adr[5:2]];
  end

  always @(posedge clk) begin
    rd_wait <= (o_s_stb && !o_s_we && !s_ack) ? rd_wait + 2'd1 : 2'd0;
    if (o_s_stb && o_s_we && s_ack && !s_err) begin
      for (int b = 0; b < 4; b++) begin
        if (o_s_sel[b]) mem[o_s_adr[5:2]][8*b +: 8] <= o_s_dat[8*b +: 8];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = nobody), drain flag, last-granted master, stall count.
  int own = -1;
  bit drain = 1'b0;
  int last = 1;
  int wd = 0;

  always @(negedge clk) begin
    logic [1:0]  cyc, stb, e_ack, e_err;
    logic [31:0] e_dat [2];
    logic        act, e_stb, e_cyc, fire, hit;
    logic [1:0]  e_gnt;
    cyc   = {m1_cyc, m0_cyc};
    stb   = {m1_stb, m0_stb};
    act   = (own >= 0) && !drain;
    e_cyc = act ? cyc[own] : 1'b0;
    e_stb = act ? (cyc[own] && stb[own]) : 1'b0;
    e_gnt = !act ? 2'b00 : (own == 0 ? 2'b01 : 2'b10);
    fire  = e_stb && !s_ack && !s_err && (wd == TO);
    for (int m = 0; m < 2; m++) begin
      hit      = act && (own == m) && cyc[m] && !rst;
      e_ack[m] = hit && s_ack && !s_err;
      e_err[m] = hit && (s_err || fire);
      e_dat[m] = (act && own == m) ? s_dat : 32'h0;
    end
    check_val("grant", o_grant, e_gnt);
    check_val("s_cyc", o_s_cyc, e_cyc);
    check_val("s_stb", o_s_stb, e_stb);
    check_val("m0_ack", o_m0_ack, e_ack[0]);
    check_val("m0_err", o_m0_err, e_err[0]);
    check_val("m1_ack", o_m1_ack, e_ack[1]);
    check_val("m1_err", o_m1_err, e_err[1]);
    check_val("m0_dat", o_m0_dat, e_dat[0]);
    check_val("m1_dat", o_m1_dat, e_dat[1]);
    if (e_stb) begin
      check_val("s_adr", o_s_adr, own == 0 ? m0_adr : m1_adr);
      check_val("s_dat", o_s_dat, own == 0 ? m0_dat : m1_dat);
      check_val("s_sel", o_s_sel, own == 0 ? m0_sel : m1_sel);
      check_val("s_we",  o_s_we,  own == 0 ? m0_we : m1_we);
    end
    if (rst) begin
      own = -1; drain = 1'b0; last = 1; wd = 0;
    end else if (own < 0) begin
      if (cyc[0] && stb[0] && cyc[1] && stb[1]) own = 1 - last;
      else if (cyc[0] && stb[0]) own = 0;
      else if (cyc[1] && stb[1]) own = 1;
    end else if (drain) begin
      if (!cyc[own]) begin last = own; own = -1; drain = 1'b0; end
    end else if (!cyc[own]) begin
      last = own; own = -1; wd = 0;
    end else if (fire) begin
      drain = 1'b1; wd = 0;
    end else begin
      wd = (e_stb && !s_ack && !s_err) ? wd + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel;
    end
  endtask

  task automatic wait_resp(input int m, input int limit, output int lat,
                           output logic [31:0] rdat, output logic err);
    logic found;
    found = 1'b0; lat = limit; rdat = '0; err = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m == 0 ? (o_m0_ack | o_m0_err) : (o_m1_ack | o_m1_err)) begin
        found = 1'b1; lat = i;
        rdat  = (m == 0) ? o_m0_dat : o_m1_dat;
        err   = (m == 0) ? o_m0_err : o_m1_err;
        break;
      end
    end
    check_val("resp_seen", found, 1);
  endtask

  task automatic wait_gnt(input logic [1:0] target, input int limit, output int lat);
    logic found;
    found = 1'b0; lat = limit;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (o_grant == target) begin found = 1'b1; lat = i; break; end
    end
    check_val("grant_seen", found, 1);
  endtask

  task automatic rnd_master(input int m, input logic resp);
    logic cyc, stb, we;
    logic [31:0] adr, dat;
    logic [3:0] sel;
    cyc = (m == 0) ? m0_cyc : m1_cyc;
    stb = (m == 0) ? m0_stb : m1_stb;
    we  = (m == 0) ? m0_we  : m1_we;
    adr = (m == 0) ? m0_adr : m1_adr;
    dat = (m == 0) ? m0_dat : m1_dat;
    sel = (m == 0) ? m0_sel : m1_sel;
    if (!cyc || (resp && $urandom_range(1) == 0)) begin
      cyc = !cyc && ($urandom_range(3) == 0);
      stb = cyc;
      we  = $urandom_range(1) == 1;
      adr = $urandom & 32'h3C;
      dat = $urandom;
      sel = 4'($urandom_range(15, 1));
    end else if ($urandom_range(15) == 0) begin
      cyc = 1'b0; stb = 1'b0;
    end else if (resp || !stb) begin
      stb = $urandom_range(1) == 1;
      we  = $urandom_range(1) == 1;
      adr = $urandom & 32'h3C;
      dat = $urandom;
    end
    set_m(m, cyc, stb, we, adr, dat, sel);
  endtask

  initial begin
    int          lat;
    logic [31:0] rdat;
    logic        err, r0, r1;
    logic [1:0]  e;
    rst = 1'b1; mute = 1'b0; force_ack = 1'b0; force_err = 1'b0;
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_grant", o_grant, 0);
    check_val("rst_s_stb", o_s_stb, 0);
    check_val("rst_s_cyc", o_s_cyc, 0);

    // Single write then read-back through the memory stub.
    tick(); set_m(0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    wait_resp(0, 10, lat, rdat, err);
    check_val("wr_lat", lat, 1);
    check_val("wr_m1_ack", o_m1_ack, 0);
    tick(); set_m(0, 0, 0, 0, 32'h100, 0, 4'hF);
    tick(); set_m(0, 1, 1, 0, 32'h100, 0, 4'hF);
    wait_resp(0, 10, lat, rdat, err);
    check_val("rd_lat", lat, 3);
    check_val("rd_data", rdat, 32'hDEADBEEF);
    check_val("rd_m1_ack", o_m1_ack, 0);
    tick(); set_m(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Both request out of reset: strict alternation m0, m1, m0, m1.
    rst = 1'b1; tick(); rst = 1'b0;
    set_m(0, 1, 1, 1, 32'h104, 32'h11111111, 4'hF);
    set_m(1, 1, 1, 1, 32'h108, 32'h22222222, 4'hF);
    for (int r = 0; r < 4; r++) begin
      e = (r % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(e, 8, lat);
      check_val("rr_lat", lat, 1);
      tick(); set_m(r % 2, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick();
      if (r < 3) set_m(r % 2, 1, 1, 1, 32'h10C, 32'h33333333, 4'hF);
      else       set_m(0, 0, 0, 0, 0, 0, 0);
    end
    tick(); tick();

    // m1 locks the bus across three reads with strobe gaps while m0 keeps requesting.
    tick(); set_m(1, 1, 1, 0, 32'h100, 0, 4'hF);
    tick(); set_m(0, 1, 1, 1, 32'h114, 32'h44444444, 4'hF);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin tick(); m1_stb = 1'b1; end
      wait_resp(1, 10, lat, rdat, err);
      check_val("lock_grant", o_grant, 2'b10);
      check_val("lock_rdata", rdat, 32'hDEADBEEF);
      tick(); m1_stb = 1'b0;
      @(negedge clk);
      check_val("lock_gap", o_grant, 2'b10);
    end
    tick(); set_m(1, 0, 0, 0, 0, 0, 0);
    wait_gnt(2'b01, 8, lat);
    check_val("lock_handover", lat, 2);
    tick(); set_m(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Silent slave: watchdog errors m0, DRAIN blocks the slave and late acks.
    mute = 1'b1;
    tick(); set_m(0, 1, 1, 1, 32'h118, 32'h55555555, 4'hF);
    wait_resp(0, 20, lat, rdat, err);
    check_val("wd_lat", lat, 1 + TO);
    check_val("wd_err", err, 1);
    tick();
    @(negedge clk);
    check_val("drain_s_stb", o_s_stb, 0);
    check_val("drain_err", o_m0_err, 0);
    check_val("drain_grant", o_grant, 0);
    tick(); force_ack = 1'b1;
    @(negedge clk);
    check_val("drain_late_ack", o_m0_ack, 0);
    tick(); force_ack = 1'b0; set_m(0, 0, 0, 0, 0, 0, 0);
    mute = 1'b0;
    tick(); tick();

    // Reset while an m1 read ack is due in the same cycle.
    tick(); set_m(1, 1, 1, 0, 32'h100, 0, 4'hF);
    tick(); tick();
    tick(); rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_ack", o_m1_ack, 0);
    tick(); rst = 1'b0; set_m(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("rst_mid_grant", o_grant, 0);
    check_val("rst_mid_stb", o_s_stb, 0);
    tick(); set_m(0, 1, 1, 1, 32'h11C, 32'h66666666, 4'hF);
    wait_resp(0, 10, lat, rdat, err);
    check_val("post_rst_lat", lat, 1);
    tick(); set_m(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Slave error after three stalled cycles: err wins over ack and the watchdog restarts.
    mute = 1'b1;
    tick(); set_m(0, 1, 1, 1, 32'h120, 32'h77777777, 4'hF);
    tick(); tick();
    tick(); force_err = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    check_val("serr_err", o_m0_err, 1);
    check_val("serr_ack", o_m0_ack, 0);
    tick(); force_err = 1'b0; force_ack = 1'b0;
    wait_resp(0, 20, lat, rdat, err);
    check_val("serr_wd_restart", lat, TO);
    tick(); set_m(0, 0, 0, 0, 0, 0, 0);
    mute = 1'b0;
    tick(); tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r0 = o_m0_ack | o_m0_err;
      r1 = o_m1_ack | o_m1_err;
      tick();
      rst       = $urandom_range(149) == 0;
      force_ack = $urandom_range(39) == 0;
      force_err = $urandom_range(39) == 0;
      if ($urandom_range(49) == 0) mute = !mute;
      rnd_master(0, r0);
      rnd_master(1, r1);
    end
    tick();
    rst = 1'b0; mute = 1'b0; force_ack = 1'b0; force_err = 1'b0;
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
